// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole engine.
// State encoding plus the default LFSR seed and Galois feedback mask.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR used as the mole position source.
// Exposes only the low OUT_W bits that the index reduction needs.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          OUT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_bits
);

    logic [15:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_bits = r_state[OUT_W-1:0];

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: LFSR-driven one-hot mole LEDs, synchronised
// active-low keys, saturating hit/miss/wrong scores over a fixed round count.
module mole_game_core
    import mole_pkg::*;
#(
    parameter int          NUM_MOLES   = 4,
    parameter int          MOLE_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES  = 25_000_000,
    parameter int          ROUNDS      = 16,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [NUM_MOLES-1:0] KEY,
    input  logic                 start,
    output logic [NUM_MOLES-1:0] LEDR,
    output logic [SCORE_W-1:0]   hits,
    output logic [SCORE_W-1:0]   misses,
    output logic [SCORE_W-1:0]   wrong,
    output logic                 game_over
);

    localparam int             IDX_W     = $clog2(NUM_MOLES);
    localparam int             NM_LAST   = NUM_MOLES - 1;
    localparam logic [IDX_W:0] C_NM      = NUM_MOLES[IDX_W:0];
    localparam logic [IDX_W:0] C_NM_LAST = NM_LAST[IDX_W:0];
    localparam logic [31:0]    GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]    MOLE_LAST = 32'(MOLE_CYCLES - 1);
    localparam logic [7:0]     C_ROUNDS  = ROUNDS[7:0];

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    state_t                r_state, w_state_nx;
    logic [31:0]           r_timer, w_timer_nx;
    logic [7:0]            r_round, w_round_nx;
    logic [NUM_MOLES-1:0]  r_leds, w_leds_nx;
    logic [SCORE_W-1:0]    r_hits, w_hits_nx;
    logic [SCORE_W-1:0]    r_misses, w_misses_nx;
    logic [SCORE_W-1:0]    r_wrong, w_wrong_nx;
    logic [IDX_W-1:0]      r_prev_idx, w_prev_nx;
    logic                  r_game_over;

    logic [NUM_MOLES-1:0]  w_press;
    logic [IDX_W-1:0]      w_lfsr_bits;
    logic [IDX_W:0]        w_raw, w_red;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_MOLES-1:0]  w_onehot;
    logic                  w_hit, w_wrong_press, w_gap_tc, w_mole_tc;
    logic [7:0]            w_round_inc;

    // Two-flop synchroniser, then a registered falling-edge pulse per key.
    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_key
        logic r_s1, r_s2, r_last, r_pulse;
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_last  <= 1'b1;
                r_pulse <= 1'b0;
            end else begin
                r_s1    <= KEY[g];
                r_s2    <= r_s1;
                r_last  <= r_s2;
                r_pulse <= r_last & ~r_s2;
            end
        end
        assign w_press[g] = r_pulse;
    end

    mole_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (IDX_W)
    ) u_lfsr (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_en    (1'b1),
        .o_bits  (w_lfsr_bits)
    );

    // Fold the raw LFSR bits into range, then step past the previous mole.
    assign w_raw    = {1'b0, w_lfsr_bits};
    assign w_red    = (w_raw >= C_NM) ? (w_raw - C_NM) : w_raw;
    assign w_idx    = (w_red[IDX_W-1:0] != r_prev_idx) ? w_red[IDX_W-1:0] :
                      (w_red == C_NM_LAST) ? '0 : w_red[IDX_W-1:0] + IDX_W'(1);
    assign w_onehot = NUM_MOLES'(1) << w_idx;

    assign w_hit         = |(w_press & r_leds);
    assign w_wrong_press = |(w_press & ~r_leds);
    assign w_gap_tc      = (r_timer == GAP_LAST);
    assign w_mole_tc     = (r_timer == MOLE_LAST);
    assign w_round_inc   = r_round + 8'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_round_nx  = r_round;
        w_leds_nx   = r_leds;
        w_hits_nx   = r_hits;
        w_misses_nx = r_misses;
        w_wrong_nx  = r_wrong;
        w_prev_nx   = r_prev_idx;
        if (start) begin
            w_state_nx  = GAP;
            w_timer_nx  = '0;
            w_round_nx  = '0;
            w_leds_nx   = '0;
            w_hits_nx   = '0;
            w_misses_nx = '0;
            w_wrong_nx  = '0;
        end else begin
            case (r_state)
                GAP: begin
                    if (w_gap_tc) begin
                        w_leds_nx  = w_onehot;
                        w_prev_nx  = w_idx;
                        w_timer_nx = '0;
                        w_state_nx = UP;
                    end else begin
                        w_timer_nx = r_timer + 32'd1;
                    end
                end
                UP: begin
                    if (w_wrong_press) w_wrong_nx = sat_inc(r_wrong);
                    // A hit on the terminal cycle still counts as a hit.
                    if (w_hit || w_mole_tc) begin
                        if (w_hit) w_hits_nx = sat_inc(r_hits);
                        else       w_misses_nx = sat_inc(r_misses);
                        w_round_nx = w_round_inc;
                        w_leds_nx  = '0;
                        w_timer_nx = '0;
                        w_state_nx = (w_round_inc == C_ROUNDS) ? DONE : GAP;
                    end else begin
                        w_timer_nx = r_timer + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_round     <= '0;
            r_leds      <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
            r_wrong     <= '0;
            r_prev_idx  <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_timer     <= w_timer_nx;
            r_round     <= w_round_nx;
            r_leds      <= w_leds_nx;
            r_hits      <= w_hits_nx;
            r_misses    <= w_misses_nx;
            r_wrong     <= w_wrong_nx;
            r_prev_idx  <= w_prev_nx;
            r_game_over <= (w_state_nx == DONE);
        end
    end

    assign LEDR      = r_leds;
    assign hits      = r_hits;
    assign misses    = r_misses;
    assign wrong     = r_wrong;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core: timing, scoring, index rules, async
// reset and saturation, using four differently parameterised instances.
module tb_mole_game_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_m, rst_n_a;
    logic [3:0] key_m, key_s;
    logic       start_m, start_s, start_a;

    logic [3:0] led_m;  logic [7:0] hits_m, misses_m, wrong_m; logic go_m;
    logic [3:0] led_s;  logic [1:0] hits_s, misses_s, wrong_s; logic go_s;
    logic [2:0] led_3;  logic [7:0] hits_3, misses_3, wrong_3; logic go_3;
    logic [4:0] led_5;  logic [7:0] hits_5, misses_5, wrong_5; logic go_5;

    int n_cmp = 0;
    int n_bad = 0;

    mole_game_core #(.NUM_MOLES(4), .MOLE_CYCLES(20), .GAP_CYCLES(5), .ROUNDS(3)) u_main (
        .CLOCK_50(clk), .RESET_N(rst_n_m), .KEY(key_m), .start(start_m),
        .LEDR(led_m), .hits(hits_m), .misses(misses_m), .wrong(wrong_m), .game_over(go_m));

    mole_game_core #(.NUM_MOLES(4), .MOLE_CYCLES(20), .GAP_CYCLES(5), .ROUNDS(6),
                     .SCORE_W(2)) u_sat (
        .CLOCK_50(clk), .RESET_N(rst_n_a), .KEY(key_s), .start(start_s),
        .LEDR(led_s), .hits(hits_s), .misses(misses_s), .wrong(wrong_s), .game_over(go_s));

    mole_game_core #(.NUM_MOLES(3), .MOLE_CYCLES(2), .GAP_CYCLES(1), .ROUNDS(200)) u_idx3 (
        .CLOCK_50(clk), .RESET_N(rst_n_a), .KEY(3'b111), .start(start_a),
        .LEDR(led_3), .hits(hits_3), .misses(misses_3), .wrong(wrong_3), .game_over(go_3));

    mole_game_core #(.NUM_MOLES(5), .MOLE_CYCLES(2), .GAP_CYCLES(1), .ROUNDS(200)) u_idx5 (
        .CLOCK_50(clk), .RESET_N(rst_n_a), .KEY(5'b11111), .start(start_a),
        .LEDR(led_5), .hits(hits_5), .misses(misses_5), .wrong(wrong_5), .game_over(go_5));

    // Track each new mole of the index instances: count, one-hot, repeats.
    logic [2:0] l3_prev = '0, l3_last = '0;
    logic [4:0] l5_prev = '0, l5_last = '0;
    int c3 = 0, rep3 = 0, bad3 = 0;
    int c5 = 0, rep5 = 0, bad5 = 0;

    always @(negedge clk) begin
        if (led_3 != 3'b000 && l3_prev == 3'b000) begin
            c3 = c3 + 1;
            if (!$onehot(led_3)) bad3 = bad3 + 1;
            if (led_3 == l3_last) rep3 = rep3 + 1;
            l3_last = led_3;
        end
        l3_prev = led_3;
        if (led_5 != 5'b00000 && l5_prev == 5'b00000) begin
            c5 = c5 + 1;
            if (!$onehot(led_5)) bad5 = bad5 + 1;
            if (led_5 == l5_last) rep5 = rep5 + 1;
            l5_last = led_5;
        end
        l5_prev = led_5;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int         lit_cnt, nonhot;
        int         idx, u1, u2, w;
        logic [3:0] p4, p5, p24, p25, lit_v;
        logic [7:0] miss25;

        rst_n_m = 1'b0; rst_n_a = 1'b0;
        key_m = 4'hF; key_s = 4'hF;
        start_m = 1'b0; start_s = 1'b0; start_a = 1'b0;
        p4 = '0; p5 = '0; p24 = '0; p25 = '0; miss25 = '0;

        // Reset state
        cyc(3);
        check("rst_led",    32'(led_m), 0);
        check("rst_hits",   32'(hits_m), 0);
        check("rst_misses", 32'(misses_m), 0);
        check("rst_wrong",  32'(wrong_m), 0);
        check("rst_go",     32'(go_m), 0);
        rst_n_m = 1'b1; rst_n_a = 1'b1;
        cyc(2);
        check("idle_led", 32'(led_m), 0);

        start_a = 1'b1; cyc(1); start_a = 1'b0;

        // Start held high keeps restarting with LEDR dark
        start_m = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("start_held_led", 32'(led_m), 0);
        end
        start_m = 1'b0;

        // No keys: three 20-cycle moles after 5-cycle gaps, all misses
        lit_cnt = 0; nonhot = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (led_m != 4'h0) begin
                lit_cnt++;
                if (!$onehot(led_m)) nonhot++;
            end
            if (i == 3)  p4 = led_m;
            if (i == 4)  p5 = led_m;
            if (i == 23) p24 = led_m;
            if (i == 24) begin p25 = led_m; miss25 = misses_m; end
        end
        check("t1_gap_end_dark", 32'(p4), 0);
        check("t1_first_lit",    32'($onehot(p5)), 1);
        check("t1_last_lit",     32'(p24), 32'(p5));
        check("t1_timeout_dark", 32'(p25), 0);
        check("t1_miss_after1",  32'(miss25), 1);
        check("t1_lit_cycles",   32'(lit_cnt), 60);
        check("t1_nonhot",       32'(nonhot), 0);
        check("t1_misses",       32'(misses_m), 3);
        check("t1_hits",         32'(hits_m), 0);
        check("t1_go",           32'(go_m), 1);
        check("t1_led_done",     32'(led_m), 0);

        // Restart from DONE, hit every mole 5 cycles in
        start_m = 1'b1; cyc(1); start_m = 1'b0;
        check("t2_go_cleared",     32'(go_m), 0);
        check("t2_misses_cleared", 32'(misses_m), 0);
        for (int r = 0; r < 3; r++) begin
            cyc(5);
            check("t2_lit", 32'($onehot(led_m)), 1);
            idx = idx_of(led_m);
            cyc(4);
            key_m[idx] = 1'b0;
            cyc(3);
            check("t2_still_lit", 32'(led_m != 4'h0), 1);
            cyc(1);
            check("t2_cleared", 32'(led_m), 0);
            check("t2_hits",    32'(hits_m), 32'(r + 1));
            key_m = 4'hF;
        end
        check("t2_misses", 32'(misses_m), 0);
        check("t2_wrong",  32'(wrong_m), 0);
        check("t2_go",     32'(go_m), 1);
        key_m = 4'h0; cyc(6); key_m = 4'hF; cyc(2);
        check("done_press_hits",  32'(hits_m), 3);
        check("done_press_wrong", 32'(wrong_m), 0);
        check("done_press_led",   32'(led_m), 0);

        // Wrong presses, hit on terminal cycle, hit+wrong, async reset
        start_m = 1'b1; cyc(1); start_m = 1'b0;
        key_m[0] = 1'b0;
        cyc(4);
        key_m = 4'hF;
        cyc(1);
        check("gap_press_lit",   32'($onehot(led_m)), 1);
        check("gap_press_wrong", 32'(wrong_m), 0);
        check("gap_press_hits",  32'(hits_m), 0);
        idx = idx_of(led_m);
        lit_v = led_m;
        u1 = (idx + 1) % 4;
        u2 = (idx + 2) % 4;
        key_m = ~((4'b0001 << u1) | (4'b0001 << u2));
        cyc(4);
        check("t3_wrong_once", 32'(wrong_m), 1);
        check("t3_wrong_lit",  32'(led_m), 32'(lit_v));
        key_m = 4'hF;
        cyc(12);
        key_m[idx] = 1'b0;
        cyc(3);
        check("t3_tc_still_lit", 32'(led_m), 32'(lit_v));
        check("t3_tc_hits0",     32'(hits_m), 0);
        cyc(1);
        check("t3_tc_led",    32'(led_m), 0);
        check("t3_tc_hits",   32'(hits_m), 1);
        check("t3_tc_misses", 32'(misses_m), 0);
        key_m = 4'hF;
        cyc(5);
        check("t3_r2_lit", 32'($onehot(led_m)), 1);
        key_m = 4'h0;
        cyc(4);
        check("t3_both_hits",  32'(hits_m), 2);
        check("t3_both_wrong", 32'(wrong_m), 2);
        key_m = 4'hF;
        cyc(5);
        check("t3_r3_lit", 32'($onehot(led_m)), 1);
        cyc(3);
        #2 rst_n_m = 1'b0;
        #1;
        check("async_led",    32'(led_m), 0);
        check("async_hits",   32'(hits_m), 0);
        check("async_wrong",  32'(wrong_m), 0);
        check("async_misses", 32'(misses_m), 0);
        check("async_go",     32'(go_m), 0);
        @(negedge clk) rst_n_m = 1'b1;
        cyc(3);
        check("post_rst_idle_led", 32'(led_m), 0);

        // Saturation with 2-bit scores over six hit rounds
        start_s = 1'b1; cyc(1); start_s = 1'b0;
        for (int r = 0; r < 6; r++) begin
            w = 0;
            while (w < 30 && led_s == 4'h0) begin cyc(1); w++; end
            check("sat_lit", 32'($onehot(led_s)), 1);
            idx = idx_of(led_s);
            key_s[idx] = 1'b0;
            cyc(4);
            check("sat_led_clear", 32'(led_s), 0);
            check("sat_hits", 32'(hits_s), (r + 1 > 3) ? 3 : 32'(r + 1));
            key_s = 4'hF;
        end
        check("sat_go",     32'(go_s), 1);
        check("sat_misses", 32'(misses_s), 0);
        check("sat_wrong",  32'(wrong_s), 0);
        start_s = 1'b1; cyc(1); start_s = 1'b0;
        check("sat_restart_hits", 32'(hits_s), 0);
        check("sat_restart_go",   32'(go_s), 0);
        check("sat_restart_led",  32'(led_s), 0);
        cyc(5);
        check("sat_restart_lit", 32'($onehot(led_s)), 1);

        // Index rules over 200 rounds for NUM_MOLES = 3 and 5
        w = 0;
        while (w < 1000 && !(go_3 && go_5)) begin cyc(1); w++; end
        check("idx_done3",   32'(go_3), 1);
        check("idx_done5",   32'(go_5), 1);
        check("idx_count3",  32'(c3), 200);
        check("idx_count5",  32'(c5), 200);
        check("idx_repeat3", 32'(rep3), 0);
        check("idx_repeat5", 32'(rep5), 0);
        check("idx_onehot3", 32'(bad3), 0);
        check("idx_onehot5", 32'(bad5), 0);
        check("idx_miss3",   32'(misses_3), 200);
        check("idx_miss5",   32'(misses_5), 200);
        check("idx_quiet3",  32'(hits_3) + 32'(wrong_3), 0);
        check("idx_quiet5",  32'(hits_5) + 32'(wrong_5), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
